tuner_sweep: RTL and testbench
==============================

# tuner_sweep

Frequency sweep/hop controller that drives the `frq` and `ns_ena` inputs of the real-to-complex tuner. It steps the tuning word from a start value to a stop value in fixed increments. After each retune it holds a settle window of fixed length, during which downstream consumers blank samples, and then a programmable dwell window. It supports single-pass and continuous sweeps and sits between the host register interface and the tuner in the receive chain.

## Interface
Parameters:
- `fsz`, 26, tuning-word width; must equal the tuner's `fsz`; requires `fsz >= dwsz+2`
- `dwsz`, 16, dwell counter width
- `stl`, 4, settle cycles after each retune (≥1; covers tuner pipeline plus filter flush)

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `cfg_we`  in  1  config write strobe
- `cfg_addr`  in  2  0 = f_start, 1 = f_stop, 2 = f_step, 3 = control
- `cfg_wdata`  in  fsz  write data; control register: [dwsz-1:0] dwell, [dwsz] continuous, [dwsz+1] ns
- `start`  in  1  1-cycle start pulse
- `stop`  in  1  1-cycle abort pulse
- `frq`  out  fsz  tuning word to tuner
- `ns_ena`  out  1  noise-shaping enable to tuner
- `busy`  out  1  sweep in progress
- `settle`  out  1  samples invalid (retune in progress)
- `step_stb`  out  1  pulse on the last dwell cycle of each point
- `done`  out  1  pulse when a single-pass sweep completes

## Operation
- Config registers are writable at any time. All registers reset to 0.
- On an accepted `start`, all four registers are copied into shadow registers. The sweep uses only the shadow copies, so writes during a sweep take effect at the next `start`.
- `ns_ena` = shadow ns bit; it is 0 from reset until the first start.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - `busy` = 0; `frq` holds its last value.
  - `start` (without `stop`): frq ← f_start, direction ← up, enter SETTLE.
- SETTLE:
  - `settle` = 1 for exactly `stl` cycles, then enter DWELL.
- DWELL:
  - `settle` = 0 for `max(dwell,1)` cycles (dwell = 0 behaves as 1).
  - On the last cycle, `step_stb` = 1 and the next point is computed.
- Next point, up direction: next = frq + f_step, computed fsz+1 wide.
  - Carry out, or next > f_stop (unsigned): end of pass.
  - Otherwise frq ← next, enter SETTLE.
- End of pass:
  - Continuous: frq ← f_start, enter SETTLE.
  - Single: `done` pulse, enter IDLE, frq holds the last point.
- f_step = 0: `start` is ignored (stays IDLE).
- f_start > f_stop: the pass consists of f_start only.
- `stop`: from any non-IDLE state, go to IDLE on the next edge. `frq` holds, no `done` pulse.
- `start` while busy is ignored. `start` and `stop` in the same cycle: stop wins (from IDLE, remain IDLE).
- Reset asserted mid-sweep: all state and outputs return immediately to reset values.

## Timing
- Reset values: frq = 0, ns_ena = 0, busy = 0, settle = 0, step_stb = 0, done = 0.
- `start` sampled at edge N → at N+1: frq = f_start, busy = 1, settle = 1.
- Per point: settle high for `stl` cycles, then low for `max(dwell,1)` cycles.
  - Point period = stl + max(dwell,1) cycles.
- `frq` changes only on the edge that enters SETTLE. `settle` rises on that same edge.
- `step_stb` is high during the final DWELL cycle. A new frq (or IDLE plus `done`) follows at the next edge.
- `done` is a 1-cycle pulse coincident with busy falling.

## Configuration
- `TUNER_SWEEP_PINGPONG_EN` defined: end of pass reverses direction instead of wrapping.
  - Up direction: when next exceeds f_stop, direction ← down and frq ← frq − f_step.
  - Down direction: next = frq − f_step. Borrow, or next < f_start, reverses direction back to up.
  - If the reversed step would also leave [f_start, f_stop], frq holds at its current value.
  - Continuous mode bounces indefinitely.
  - Single mode: the pass ends (`done`, IDLE) on the down→up reversal.
- Macro undefined: wrap-to-f_start behaviour only; the direction register and subtractor are not built.

## Test plan
- Basic single pass: f_start = 100, f_stop = 130, f_step = 10, dwell = 3, single, stl = 4.
  - frq sequence 100, 110, 120, 130, then `done`; busy high 28 cycles; four `step_stb` pulses.
- Continuous wrap: same config with continuous = 1.
  - After 130, frq returns to 100 with settle = 1; `done` never asserts.
- Wrap edge: f_start = 2^26−20, f_stop = 2^26−1, f_step = 16.
  - Points 2^26−20 and 2^26−4; the carry ends the pass; frq never shows a small wrapped value.
- Stop and collisions:
  - `stop` during DWELL at frq = 110 → IDLE next cycle, frq stays 110, no `done`.
  - `start` and `stop` together in IDLE → remains IDLE.
- Degenerate configs:
  - dwell = 0 → 1-cycle dwell.
  - f_step = 0 → `start` ignored.
  - f_start = 50 > f_stop = 40 → single point 50, then `done`.
  - A write to f_stop mid-sweep does not alter the current pass.
- Pingpong (macro defined): 100/130/10, single.
  - frq 100, 110, 120, 130, 120, 110, 100, then `done`.
  - Async reset mid-sweep forces all outputs to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/tuner_sweep.sv
// Sweep/hop controller for the real-to-complex tuner: steps frq from f_start to f_stop with settle + dwell windows.
// Optional TUNER_SWEEP_PINGPONG_EN: bounce between the range ends instead of wrapping to f_start.
module tuner_sweep #(
    parameter int fsz  = 26,
    parameter int dwsz = 16,
    parameter int stl  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [fsz-1:0]  cfg_wdata,
    input  logic            start,
    input  logic            stop,
    output logic [fsz-1:0]  frq,
    output logic            ns_ena,
    output logic            busy,
    output logic            settle,
    output logic            step_stb,
    output logic            done
);

    localparam int csz = dwsz + 2;
    localparam logic [dwsz-1:0] stl_last = dwsz'(stl - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

    state_t state_q, state_d;
    logic [fsz-1:0]  f_start_q, f_start_d, f_stop_q, f_stop_d, f_step_q, f_step_d;
    logic [csz-1:0]  ctrl_q, ctrl_d;
    logic [fsz-1:0]  sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
    logic [csz-1:0]  sh_ctrl_q, sh_ctrl_d;
    logic [fsz-1:0]  frq_q, frq_d;
    logic [dwsz-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [dwsz-1:0] sh_dwell, dwell_last;
    logic [fsz:0]    sum_up;
    logic            up_out, cont;

    assign sh_dwell   = sh_ctrl_q[dwsz-1:0];
    assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - dwsz'(1);
    assign cont       = sh_ctrl_q[dwsz];
    // Extra bit catches the carry so a wrap past 2^fsz ends the pass.
    assign sum_up     = {1'b0, frq_q} + {1'b0, sh_step_q};
    assign up_out     = sum_up[fsz] | (sum_up[fsz-1:0] > sh_stop_q);

`ifdef TUNER_SWEEP_PINGPONG_EN
    logic         dir_q, dir_d;   // 1 = stepping down
    logic [fsz:0] dif_dn;
    logic         dn_out;
    assign dif_dn = {1'b0, frq_q} - {1'b0, sh_step_q};
    assign dn_out = dif_dn[fsz] | (dif_dn[fsz-1:0] < sh_start_q);
`endif

    always_comb begin
        f_start_d = f_start_q;
        f_stop_d  = f_stop_q;
        f_step_d  = f_step_q;
        ctrl_d    = ctrl_q;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: f_start_d = cfg_wdata;
                2'd1: f_stop_d  = cfg_wdata;
                2'd2: f_step_d  = cfg_wdata;
                default: ctrl_d = cfg_wdata[csz-1:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        frq_d      = frq_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        sh_start_d = sh_start_q;
        sh_stop_d  = sh_stop_q;
        sh_step_d  = sh_step_q;
        sh_ctrl_d  = sh_ctrl_q;
`ifdef TUNER_SWEEP_PINGPONG_EN
        dir_d      = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop && f_step_q != '0) begin
                    sh_start_d = f_start_q;
                    sh_stop_d  = f_stop_q;
                    sh_step_d  = f_step_q;
                    sh_ctrl_d  = ctrl_q;
                    frq_d      = f_start_q;
                    cnt_d      = '0;
                    state_d    = SETTLE;
`ifdef TUNER_SWEEP_PINGPONG_EN
                    dir_d      = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == stl_last) begin
                    cnt_d   = '0;
                    state_d = DWELL;
                end else begin
                    cnt_d = cnt_q + dwsz'(1);
                end
            end
            DWELL: begin
                if (cnt_q == dwell_last) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
`ifdef TUNER_SWEEP_PINGPONG_EN
                    if (!dir_q) begin
                        if (!up_out) begin
                            frq_d = sum_up[fsz-1:0];
                        end else begin
                            dir_d = 1'b1;
                            if (!dn_out) frq_d = dif_dn[fsz-1:0];
                        end
                    end else if (!dn_out) begin
                        frq_d = dif_dn[fsz-1:0];
                    end else if (!cont) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dir_d = 1'b0;
                        if (!up_out) frq_d = sum_up[fsz-1:0];
                    end
`else
                    if (!up_out) begin
                        frq_d = sum_up[fsz-1:0];
                    end else if (cont) begin
                        frq_d = sh_start_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + dwsz'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort beats everything, including the end-of-pass done pulse.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            frq_d   = frq_q;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            f_start_q  <= '0;
            f_stop_q   <= '0;
            f_step_q   <= '0;
            ctrl_q     <= '0;
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_step_q  <= '0;
            sh_ctrl_q  <= '0;
            frq_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_start_q  <= f_start_d;
            f_stop_q   <= f_stop_d;
            f_step_q   <= f_step_d;
            ctrl_q     <= ctrl_d;
            sh_start_q <= sh_start_d;
            sh_stop_q  <= sh_stop_d;
            sh_step_q  <= sh_step_d;
            sh_ctrl_q  <= sh_ctrl_d;
            frq_q      <= frq_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

`ifdef TUNER_SWEEP_PINGPONG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dir_q <= 1'b0;
        else          dir_q <= dir_d;
    end
`endif

    assign frq      = frq_q;
    assign ns_ena   = sh_ctrl_q[dwsz+1];
    assign busy     = (state_q != IDLE);
    assign settle   = (state_q == SETTLE);
    assign step_stb = (state_q == DWELL) && (cnt_q == dwell_last);
    assign done     = done_q;

endmodule

// File: tb/tb_tuner_sweep.sv
// Directed bench for tuner_sweep: single/continuous sweeps, wrap edge, stop, degenerate configs, async reset.
// Pingpong expectations are exercised when TUNER_SWEEP_PINGPONG_EN is defined.
module tb_tuner_sweep;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [25:0] cfg_wdata;
    logic        start;
    logic        stop;
    logic [25:0] frq;
    logic        ns_ena;
    logic        busy;
    logic        settle;
    logic        step_stb;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    int nb, ns, nd, nst;
    bit to;

    tuner_sweep #(.fsz(26), .dwsz(16), .stl(4)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .frq(frq),
        .ns_ena(ns_ena), .busy(busy), .settle(settle), .step_stb(step_stb), .done(done)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Driver tasks: called at a negedge, return at a later negedge.
    task automatic cfg(input logic [1:0] a, input logic [25:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic setup(input logic [25:0] fs, input logic [25:0] fe, input logic [25:0] st, input logic [25:0] c);
        cfg(2'd0, fs); cfg(2'd1, fe); cfg(2'd2, st); cfg(2'd3, c);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records the frq of every point (sampled when settle rises) and per-cycle counts.
    task automatic run_sweep(input int max_cyc, input bit until_idle,
                             output int n_busy, output int n_stb, output int n_done,
                             output int n_settle, output bit timed_out);
        bit prev_settle;
        bit fin;
        prev_settle = 1'b0; fin = 1'b0;
        n_busy = 0; n_stb = 0; n_done = 0; n_settle = 0;
        timed_out = until_idle;
        got_q.delete();
        for (int c = 0; c < max_cyc && !fin; c++) begin
            if (busy) begin
                n_busy++;
                if (settle) n_settle++;
                if (settle && !prev_settle) got_q.push_back(32'(frq));
                if (step_stb) n_stb++;
            end
            if (done) n_done++;
            prev_settle = settle;
            if (until_idle && !busy) begin
                fin = 1'b1;
                timed_out = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Scoreboard: compare recorded points against the expected queue.
    task automatic cmp_points(input string tag);
        check({tag, "_npoints"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_pt%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_frq", 32'(frq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_settle", 32'(settle), 0);
        check("rst_stb", 32'(step_stb), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ns", 32'(ns_ena), 0);

        // Basic single pass, ns = 1
        setup(26'd100, 26'd130, 26'd10, 26'h20003);
        check("pre_ns", 32'(ns_ena), 0);
        pulse_start();
        check("s1_frq0", 32'(frq), 100);
        check("s1_busy0", 32'(busy), 1);
        check("s1_settle0", 32'(settle), 1);
        check("s1_ns", 32'(ns_ena), 1);
        run_sweep(200, 1'b1, nb, ns, nd, nst, to);
        check("s1_timeout", 32'(to), 0);
        check("s1_busy_cyc", nb, 28);
        check("s1_stb", ns, 4);
        check("s1_settle_cyc", nst, 16);
        check("s1_done", nd, 1);
        check("s1_done_now", 32'(done), 1);
        exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
        cmp_points("s1");
        @(negedge clk);
        check("s1_done_pulse", 32'(done), 0);
        check("s1_frq_hold", 32'(frq), 130);

        // Continuous wrap, then stop during DWELL at 110
        cfg(2'd3, 26'h10003);
        pulse_start();
        run_sweep(40, 1'b0, nb, ns, nd, nst, to);
        check("c_done", nd, 0);
        check("c_ns", 32'(ns_ena), 0);
        exp_q = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd100, 32'd110};
        cmp_points("c");
        check("c_in_dwell", 32'(settle), 0);
        check("c_frq_pre_stop", 32'(frq), 110);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_frq", 32'(frq), 110);
        check("stop_done", 32'(done), 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 0);
        check("ss_settle", 32'(settle), 0);

        // Wrap edge near 2^26
        setup(26'd67108844, 26'd67108863, 26'd16, 26'd3);
        pulse_start();
        run_sweep(200, 1'b1, nb, ns, nd, nst, to);
        check("w_timeout", 32'(to), 0);
        check("w_busy_cyc", nb, 14);
        check("w_done", nd, 1);
        exp_q = '{32'd67108844, 32'd67108860};
        cmp_points("w");
        check("w_frq_hold", 32'(frq), 67108860);

        // dwell = 0 behaves as 1
        setup(26'd100, 26'd130, 26'd10, 26'd0);
        pulse_start();
        run_sweep(200, 1'b1, nb, ns, nd, nst, to);
        check("d0_timeout", 32'(to), 0);
        check("d0_busy_cyc", nb, 20);
        check("d0_stb", ns, 4);

        // f_step = 0: start ignored
        cfg(2'd2, 26'd0);
        pulse_start();
        check("z_busy", 32'(busy), 0);
        check("z_frq", 32'(frq), 130);

        // f_start > f_stop: single point
        setup(26'd50, 26'd40, 26'd10, 26'd3);
        pulse_start();
        run_sweep(200, 1'b1, nb, ns, nd, nst, to);
        check("inv_busy_cyc", nb, 7);
        check("inv_done", nd, 1);
        exp_q = '{32'd50};
        cmp_points("inv");

        // f_stop write mid-sweep does not alter the pass
        setup(26'd100, 26'd130, 26'd10, 26'd3);
        pulse_start();
        cfg(2'd1, 26'd110);
        run_sweep(200, 1'b1, nb, ns, nd, nst, to);
        check("mw_busy_cyc", nb, 27);
        check("mw_done", nd, 1);
        exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
        cmp_points("mw");

`ifdef TUNER_SWEEP_PINGPONG_EN
        // Pingpong single: up then down, done on the down->up reversal
        setup(26'd100, 26'd130, 26'd10, 26'd3);
        pulse_start();
        run_sweep(300, 1'b1, nb, ns, nd, nst, to);
        check("pp_timeout", 32'(to), 0);
        check("pp_busy_cyc", nb, 49);
        check("pp_done", nd, 1);
        exp_q = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100};
        cmp_points("pp");
`endif

        // Async reset mid-sweep: outputs clear before any clock edge
        setup(26'd100, 26'd130, 26'd10, 26'h30003);
        pulse_start();
        repeat (10) @(negedge clk);
        check("ar_busy_pre", 32'(busy), 1);
        check("ar_frq_pre", 32'(frq), 110);
        #2 reset_n = 1'b0;
        #1;
        check("ar_frq", 32'(frq), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_settle", 32'(settle), 0);
        check("ar_ns", 32'(ns_ena), 0);
        check("ar_stb", 32'(step_stb), 0);
        check("ar_done", 32'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ar_busy_after", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
